alu_seq_unit: RTL

//  Registered, parametrised ALU execution unit with internal accumulator A and operand register B.

---
 rtl/alu_seq_unit_pkg.sv | 40 ++++
 rtl/alu_seq_unit_comb.sv | 121 ++++++++++++
 rtl/alu_seq_unit.sv | 128 ++++++++++++
 3 files changed

// File: rtl/alu_seq_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Package : alu_pkg
//  Purpose : Shared definitions for the sequential ALU unit: opcode
//            encodings, FSM state type and flag bit positions.
//  Revision: 1.0  initial release
// ============================================================================
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_SHL  = 4'h2;
    localparam logic [3:0] OP_SHR  = 4'h3;
    localparam logic [3:0] OP_CMP  = 4'h4;
    localparam logic [3:0] OP_AND  = 4'h5;
    localparam logic [3:0] OP_OR   = 4'h6;
    localparam logic [3:0] OP_XOR  = 4'h7;
    localparam logic [3:0] OP_NAND = 4'h8;
    localparam logic [3:0] OP_NOR  = 4'h9;
    localparam logic [3:0] OP_XNOR = 4'hA;
    localparam logic [3:0] OP_NOT  = 4'hB;
    localparam logic [3:0] OP_NEG  = 4'hC;
    localparam logic [3:0] OP_STO  = 4'hD;
    localparam logic [3:0] OP_SWP  = 4'hE;
    localparam logic [3:0] OP_LOAD = 4'hF;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Bit positions inside the packed flag vector
    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;
    localparam int FLAG_W = 4;

endpackage
`default_nettype wire

// File: rtl/alu_seq_unit_comb.sv
`default_nettype none
// ============================================================================
//  Module  : alu_comb
//  Purpose : Purely combinational next-state compute for every op that
//            retires on its accept edge (all ops except SHL/SHR with n>0).
//  Ports   : op         opcode
//            a, b       current A and B registers
//            data       load value (LOAD only)
//            flags_in   current flags {V,C,N,Z}
//            a_next     next A
//            b_next     next B (differs from b only for SWP)
//            flags_next next flags
//  Revision: 1.0  initial release
// ============================================================================
module alu_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [3:0]        op,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic [WIDTH-1:0]  data,
    input  logic [FLAG_W-1:0] flags_in,
    output logic [WIDTH-1:0]  a_next,
    output logic [WIDTH-1:0]  b_next,
    output logic [FLAG_W-1:0] flags_next
);

    localparam int MSB = WIDTH - 1;

    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   sub_sum;
    logic [WIDTH-1:0] neg_val;
    logic [WIDTH-1:0] res;
    logic             wr_a;
    logic             upd_zn;
    logic             upd_cv;
    logic             c_new;
    logic             v_new;

    assign add_sum = {1'b0, a} + {1'b0, b};
    // Carry out of A + ~B + 1 is the "no borrow" indication
    assign sub_sum = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
    assign neg_val = '0 - a;

    always_comb begin
        res    = a;
        wr_a   = 1'b0;
        upd_zn = 1'b0;
        upd_cv = 1'b0;
        c_new  = 1'b0;
        v_new  = 1'b0;
        b_next = b;
        case (op)
            OP_ADD: begin
                res    = add_sum[WIDTH-1:0];
                wr_a   = 1'b1;
                upd_zn = 1'b1;
                upd_cv = 1'b1;
                c_new  = add_sum[WIDTH];
                v_new  = (a[MSB] == b[MSB]) && (add_sum[MSB] != a[MSB]);
            end
            OP_SUB, OP_CMP: begin
                // CMP computes the same difference but leaves A untouched
                res    = sub_sum[WIDTH-1:0];
                wr_a   = (op == OP_SUB);
                upd_zn = 1'b1;
                upd_cv = 1'b1;
                c_new  = sub_sum[WIDTH];
                v_new  = (a[MSB] != b[MSB]) && (sub_sum[MSB] != a[MSB]);
            end
            OP_SHL, OP_SHR: begin
                // Zero shift count only; non-zero counts run in the FSM
                upd_zn = 1'b1;
                upd_cv = 1'b1;
            end
            OP_AND:  begin res = a & b;    wr_a = 1'b1; upd_zn = 1'b1; upd_cv = 1'b1; end
            OP_OR:   begin res = a | b;    wr_a = 1'b1; upd_zn = 1'b1; upd_cv = 1'b1; end
            OP_XOR:  begin res = a ^ b;    wr_a = 1'b1; upd_zn = 1'b1; upd_cv = 1'b1; end
            OP_NAND: begin res = ~(a & b); wr_a = 1'b1; upd_zn = 1'b1; upd_cv = 1'b1; end
            OP_NOR:  begin res = ~(a | b); wr_a = 1'b1; upd_zn = 1'b1; upd_cv = 1'b1; end
            OP_XNOR: begin res = ~(a ^ b); wr_a = 1'b1; upd_zn = 1'b1; upd_cv = 1'b1; end
            OP_NOT:  begin res = ~a;       wr_a = 1'b1; upd_zn = 1'b1; upd_cv = 1'b1; end
            OP_NEG: begin
                res    = neg_val;
                wr_a   = 1'b1;
                upd_zn = 1'b1;
                upd_cv = 1'b1;
                c_new  = (a == '0);
                v_new  = (a == {1'b1, {(WIDTH-1){1'b0}}});
            end
            OP_SWP: begin
                res    = b;
                wr_a   = 1'b1;
                b_next = a;
            end
            OP_LOAD: begin
                res    = data;
                wr_a   = 1'b1;
                upd_zn = 1'b1;
            end
            default: begin
                // OP_STO: nothing changes, the op only retires
            end
        endcase

        a_next     = wr_a ? res : a;
        flags_next = flags_in;
        if (upd_zn) begin
            flags_next[FLAG_Z] = (res == '0);
            flags_next[FLAG_N] = res[MSB];
        end
        if (upd_cv) begin
            flags_next[FLAG_C] = c_new;
            flags_next[FLAG_V] = v_new;
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_seq_unit.sv
`default_nettype none
// ============================================================================
//  Module  : alu_seq_unit
//  Purpose : Registered ALU execution unit with accumulator A and operand
//            register B. One op per valid/ready handshake; multi-bit shifts
//            iterate one bit per cycle in the SHIFT state.
//  Ports   : clk, rst          clock, asynchronous active-high reset
//            in_valid/in_ready op handshake (ready only in IDLE)
//            in_op, in_data    opcode and load value
//            out_done          one-cycle retire pulse
//            out_result, out_b A and B registers
//            flag_z/n/c/v      zero, negative, carry, signed overflow
//  Revision: 1.0  initial release
// ============================================================================
module alu_seq_unit
    import alu_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_done,
    output logic [WIDTH-1:0] out_result,
    output logic [WIDTH-1:0] out_b,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             flag_v
);

    localparam int                 SHAMT_W   = $clog2(WIDTH) + 1;
    localparam logic [SHAMT_W-1:0] MAX_SHAMT = SHAMT_W'(WIDTH);

    state_t              state;
    logic [WIDTH-1:0]    a_reg;
    logic [WIDTH-1:0]    b_reg;
    logic [FLAG_W-1:0]   flags;
    logic [SHAMT_W-1:0]  cnt;
    logic                shift_left;
    logic                done_reg;

    logic [WIDTH-1:0]    comb_a;
    logic [WIDTH-1:0]    comb_b;
    logic [FLAG_W-1:0]   comb_flags;
    logic [SHAMT_W-1:0]  shamt_raw;
    logic [SHAMT_W-1:0]  shamt;
    logic                is_shift;
    logic [WIDTH-1:0]    shift_val;
    logic                shift_out;

    alu_comb #(.WIDTH(WIDTH)) u_comb (
        .op         (in_op),
        .a          (a_reg),
        .b          (b_reg),
        .data       (in_data),
        .flags_in   (flags),
        .a_next     (comb_a),
        .b_next     (comb_b),
        .flags_next (comb_flags)
    );

    // Shift count saturates at WIDTH: anything larger clears A just the same
    assign shamt_raw = b_reg[SHAMT_W-1:0];
    assign shamt     = (shamt_raw > MAX_SHAMT) ? MAX_SHAMT : shamt_raw;
    assign is_shift  = (in_op == OP_SHL) || (in_op == OP_SHR);

    assign shift_val = shift_left ? {a_reg[WIDTH-2:0], 1'b0} : {1'b0, a_reg[WIDTH-1:1]};
    assign shift_out = shift_left ? a_reg[WIDTH-1] : a_reg[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            a_reg      <= RESET_VAL;
            b_reg      <= RESET_VAL;
            flags      <= '0;
            cnt        <= '0;
            shift_left <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        if (is_shift && (shamt != '0)) begin
                            cnt        <= shamt;
                            shift_left <= (in_op == OP_SHL);
                            state      <= ST_SHIFT;
                        end else begin
                            a_reg    <= comb_a;
                            b_reg    <= comb_b;
                            flags    <= comb_flags;
                            done_reg <= 1'b1;
                        end
                    end
                end
                ST_SHIFT: begin
                    a_reg         <= shift_val;
                    flags[FLAG_Z] <= (shift_val == '0);
                    flags[FLAG_N] <= shift_val[WIDTH-1];
                    flags[FLAG_C] <= shift_out;
                    flags[FLAG_V] <= 1'b0;
                    cnt           <= cnt - SHAMT_W'(1);
                    if (cnt == SHAMT_W'(1)) begin
                        state    <= ST_IDLE;
                        done_reg <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready   = (state == ST_IDLE);
    assign out_done   = done_reg;
    assign out_result = a_reg;
    assign out_b      = b_reg;
    assign flag_z     = flags[FLAG_Z];
    assign flag_n     = flags[FLAG_N];
    assign flag_c     = flags[FLAG_C];
    assign flag_v     = flags[FLAG_V];

endmodule
`default_nettype wire
